// File: rtl/sr_latch_driver.sv
// Clocked writer for a cross-coupled NOR SR latch: non-overlapping set/reset pulses, synchronised Q/Q_ confirmation.
// Optional macro SR_LATCH_DRIVER_SKIP_EN: requests matching the confirmed, stable latch value complete without a pulse.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    input  logic q,
    input  logic q_,
    output logic latch_set,
    output logic latch_reset,
    output logic done,
    output logic err,
    output logic state_q
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_DRIVE = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4
    } fsm_t;

    localparam logic [7:0] PW_LD = 8'(PULSE_W);
    localparam logic [7:0] PW_M1 = 8'(PULSE_W - 1);
    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    fsm_t       fsm_q, fsm_d;
    logic [7:0] cnt_q, cnt_d;
    logic       val_q, val_d;
    logic       state_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       set_q, set_d;
    logic       rst_q, rst_d;
    logic       ready_q, ready_d;
    logic       q_meta_q, qs_q, qn_meta_q, qsn_q;
    logic       match_s, skip_s;

    // Two-flop synchronisers on the asynchronous latch feedback
    always_ff @(posedge clk) begin
        if (reset) begin
            q_meta_q  <= 1'b0;
            qs_q      <= 1'b0;
            qn_meta_q <= 1'b0;
            qsn_q     <= 1'b0;
        end else begin
            q_meta_q  <= q;
            qs_q      <= q_meta_q;
            qn_meta_q <= q_;
            qsn_q     <= qn_meta_q;
        end
    end

    // qs == qs_ is illegal feedback and can never satisfy this
    assign match_s = (qs_q == val_q) && (qsn_q == !val_q);

`ifdef SR_LATCH_DRIVER_SKIP_EN
    assign skip_s = (req_val == state_q) && (qs_q == state_q) && (qsn_q == !state_q);
`else
    assign skip_s = 1'b0;
`endif

    // State, counter, captured value and confirmed value registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= S_INIT;
            cnt_q   <= PW_LD;
            val_q   <= 1'b0;
            state_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            state_q <= state_d;
        end
    end

    // Next-state logic; cnt_q serves as pulse counter and as WAIT timeout counter
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (fsm_q)
            S_INIT: begin
                if (cnt_q == 8'd0) begin
                    fsm_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    val_d = req_val;
                    if (skip_s) begin
                        fsm_d  = S_GAP;
                        done_d = 1'b1;
                    end else begin
                        fsm_d = S_DRIVE;
                        cnt_d = PW_M1;
                    end
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    fsm_d = S_WAIT;
                    cnt_d = TO_M1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (match_s) begin
                    fsm_d   = S_GAP;
                    done_d  = 1'b1;
                    state_d = val_q;
                end else if (cnt_q == 8'd0) begin
                    fsm_d = S_GAP;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_INIT;
                cnt_d = PW_LD;
            end
        endcase
    end

    // Output decode from the next state so the pins come straight from flops
    always_comb begin
        set_d   = 1'b0;
        rst_d   = 1'b0;
        ready_d = 1'b0;
        case (fsm_d)
            S_INIT:  rst_d   = 1'b1;
            S_IDLE:  ready_d = 1'b1;
            S_DRIVE: begin
                set_d = val_d;
                rst_d = !val_d;
            end
            S_WAIT:  ready_d = 1'b0;
            S_GAP:   ready_d = 1'b0;
            default: rst_d   = 1'b1;
        endcase
    end

    // Registered output pins
    always_ff @(posedge clk) begin
        if (reset) begin
            set_q   <= 1'b0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            set_q   <= set_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign latch_set   = set_q;
    assign latch_reset = rst_q;
    assign req_ready   = ready_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
